npc_unit: RTL

- Parametrised next-PC / program-counter block for the single-cycle and upcoming pipelined MIPS cores.
- Holds the PC and computes sequential, branch, jump and register-indirect targets.
- Evaluates branch conditions internally from two register operands, instead of taking external zero flags.
- Adds stall hold, exception entry with an EPC register, ERET return, and misaligned-target trapping.

---
 rtl/npc_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/npc_unit.sv
// Program-counter register and next-PC selection for the MIPS cores, with
// in-unit branch compare, stall hold, exception/EPC handling and ERET.
module npc_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter logic [31:0] RESET_ADDR = 32'h0000_3000,
    parameter logic [31:0] EXC_ADDR   = 32'h0000_4180
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [2:0]       npc_sel,
    input  logic [2:0]       cmp_op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [25:0]      instr_index,
    input  logic [15:0]      immediate,
    input  logic             exc_req,
    input  logic             eret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] pc_prev,
    output logic [WIDTH-1:0] epc,
    output logic             branch_taken,
    output logic             addr_err
);

    typedef enum logic [2:0] {
        SEL_SEQ    = 3'b000,
        SEL_BRANCH = 3'b001,
        SEL_JUMP   = 3'b010,
        SEL_REG    = 3'b011
    } sel_e;

    typedef enum logic [2:0] {
        CMP_EQ  = 3'b000,
        CMP_NE  = 3'b001,
        CMP_LEZ = 3'b010,
        CMP_GTZ = 3'b011,
        CMP_LTZ = 3'b100,
        CMP_GEZ = 3'b101
    } cmp_e;

    localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_ADDR);
    localparam logic [WIDTH-1:0] EXC_PC   = WIDTH'(EXC_ADDR);

    logic             cond;
    logic             rs_neg;
    logic             rs_zero;
    logic             misaligned;
    logic [WIDTH-1:0] br_offset;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] npc;

    assign rs_neg      = rs_data[WIDTH-1];
    assign rs_zero     = (rs_data == '0);
    assign pc_plus4    = pc + WIDTH'(4);
    assign br_offset   = {{(WIDTH-18){immediate[15]}}, immediate, 2'b00};
    assign br_target   = pc_plus4 + br_offset;
    assign jump_target = {pc[WIDTH-1:28], instr_index, 2'b00};
    assign misaligned  = (npc_sel == SEL_REG) && (rs_data[1:0] != 2'b00);

    always_comb begin
        cond = 1'b0;
        case (cmp_op)
            CMP_EQ:  cond = (rs_data == rt_data);
            CMP_NE:  cond = (rs_data != rt_data);
            CMP_LEZ: cond = rs_neg || rs_zero;
            CMP_GTZ: cond = !rs_neg && !rs_zero;
            CMP_LTZ: cond = rs_neg;
            CMP_GEZ: cond = !rs_neg;
            default: cond = 1'b0;
        endcase
    end

    assign branch_taken = (npc_sel == SEL_BRANCH) && cond;

    always_comb begin
        npc = pc_plus4;
        case (npc_sel)
            SEL_BRANCH: npc = branch_taken ? br_target : pc_plus4;
            SEL_JUMP:   npc = jump_target;
            SEL_REG:    npc = rs_data;
            default:    npc = pc_plus4;
        endcase
    end

    // Exception and ERET bypass stall; a misaligned register jump is a trap
    // that only fires on a non-stalled cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            pc_prev  <= '0;
            epc      <= '0;
            addr_err <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            if (exc_req) begin
                epc     <= pc;
                pc      <= EXC_PC;
                pc_prev <= pc;
            end else if (eret) begin
                pc      <= epc;
                pc_prev <= pc;
            end else if (stall) begin
                pc      <= pc;
            end else if (misaligned) begin
                epc      <= pc;
                pc       <= EXC_PC;
                pc_prev  <= pc;
                addr_err <= 1'b1;
            end else begin
                pc      <= npc;
                pc_prev <= pc;
            end
        end
    end

endmodule
